// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one pipelined Wishbone bus among
// Count masters. A grant is held from grant until the owner drops cyc.
// Optional ack-wait timeout is enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter #(
    parameter int unsigned Count         = 2,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddrWidth     = 30,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [DataWidth-1:0]     wb_m_data_i  [Count],
    input  logic [AddrWidth-1:0]     wb_m_addr_i  [Count],
    input  logic [DataWidth/8-1:0]   wb_m_sel_i   [Count],
    input  logic                     wb_m_cyc_i   [Count],
    input  logic                     wb_m_stb_i   [Count],
    input  logic                     wb_m_we_i    [Count],
    output logic [DataWidth-1:0]     wb_m_data_o  [Count],
    output logic                     wb_m_ack_o   [Count],
    output logic                     wb_m_stall_o [Count],
    output logic                     wb_m_err_o   [Count],
    output logic [DataWidth-1:0]     wb_s_data_o,
    output logic [AddrWidth-1:0]     wb_s_addr_o,
    output logic [DataWidth/8-1:0]   wb_s_sel_o,
    output logic                     wb_s_cyc_o,
    output logic                     wb_s_stb_o,
    output logic                     wb_s_we_o,
    input  logic [DataWidth-1:0]     wb_s_data_i,
    input  logic                     wb_s_ack_i,
    input  logic                     wb_s_stall_i,
    input  logic                     wb_s_err_i
);

    localparam int unsigned OwnerW = (Count > 1) ? $clog2(Count) : 1;

    typedef enum logic {
        IDLE,
        GRANTED
    } state_e;

    state_e              state_q;
    logic [OwnerW-1:0]   owner_q;
    logic [OwnerW-1:0]   last_q;

    logic                owner_cyc_c;
    logic                timeout_c;
    logic                xfer_en_c;
    logic [Count-1:0]    cand_c;
    logic                pick_found_c;
    logic [OwnerW-1:0]   pick_idx_c;

    assign owner_cyc_c = wb_m_cyc_i[owner_q];

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

    logic [TmoW-1:0] tmo_cnt_q;

    // The owner's Nth cycle with shared cyc asserted is the timeout cycle
    assign timeout_c = (state_q == GRANTED) && owner_cyc_c &&
                       (tmo_cnt_q == TmoW'(TimeoutCycles - 1));

    // Count shared-cyc cycles of the current grant; any response restarts it
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tmo_cnt_q <= '0;
        end else if ((state_q != GRANTED) || !owner_cyc_c || timeout_c ||
                     wb_s_ack_i || wb_s_err_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    // Timeout limit is meaningless without the counter
    logic unused_timeout_c;
    assign unused_timeout_c = (TimeoutCycles == 0);
    assign timeout_c        = 1'b0;
`endif

    assign xfer_en_c = (state_q == GRANTED) && owner_cyc_c && !timeout_c;

    // Requesting masters; a timed-out owner is excluded from the handover
    always_comb begin
        for (int i = 0; i < Count; i++) begin
            cand_c[i] = wb_m_cyc_i[i];
        end
        if (timeout_c) begin
            cand_c[owner_q] = 1'b0;
        end
    end

    // Round-robin search starting just after the last owner
    always_comb begin
        int unsigned idx;
        idx          = 0;
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        for (int unsigned i = 1; i <= Count; i++) begin
            idx = (32'(last_q) + i) % Count;
            if (!pick_found_c && cand_c[OwnerW'(idx)]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = OwnerW'(idx);
            end
        end
    end

    // Grant state machine
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OwnerW'(Count - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found_c) begin
                        state_q <= GRANTED;
                        owner_q <= pick_idx_c;
                        last_q  <= pick_idx_c;
                    end
                end
                GRANTED: begin
                    if (!owner_cyc_c || timeout_c) begin
                        if (pick_found_c) begin
                            owner_q <= pick_idx_c;
                            last_q  <= pick_idx_c;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Forward the owner's request onto the shared bus
    always_comb begin
        wb_s_data_o = '0;
        wb_s_addr_o = '0;
        wb_s_sel_o  = '0;
        wb_s_we_o   = 1'b0;
        if (state_q == GRANTED) begin
            wb_s_data_o = wb_m_data_i[owner_q];
            wb_s_addr_o = wb_m_addr_i[owner_q];
            wb_s_sel_o  = wb_m_sel_i[owner_q];
            wb_s_we_o   = wb_m_we_i[owner_q];
        end
        wb_s_cyc_o = xfer_en_c;
        wb_s_stb_o = xfer_en_c && wb_m_stb_i[owner_q];
    end

    // Route shared responses to the owner; everyone else sees stall
    always_comb begin
        for (int i = 0; i < Count; i++) begin
            wb_m_data_o[i]  = '0;
            wb_m_ack_o[i]   = 1'b0;
            wb_m_stall_o[i] = 1'b1;
            wb_m_err_o[i]   = 1'b0;
        end
        if (state_q == GRANTED) begin
            wb_m_data_o[owner_q] = wb_s_data_i;
            if (timeout_c) begin
                wb_m_err_o[owner_q] = 1'b1;
            end else begin
                wb_m_ack_o[owner_q]   = wb_s_ack_i;
                wb_m_stall_o[owner_q] = wb_s_stall_i;
                wb_m_err_o[owner_q]   = wb_s_err_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed masters, a simple single-cycle slave and
// scoreboard monitors for shared-bus transfers and master acks.
module tb_wb_arbiter;

    localparam int unsigned N   = 2;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 30;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [DW-1:0] m_wdata [N];
    logic [AW-1:0] m_addr  [N];
    logic [SW-1:0] m_sel   [N];
    logic          m_cyc   [N];
    logic          m_stb   [N];
    logic          m_we    [N];
    logic [DW-1:0] m_rdata [N];
    logic          m_ack   [N];
    logic          m_stall [N];
    logic          m_err   [N];
    logic [DW-1:0] s_wdata;
    logic [AW-1:0] s_addr;
    logic [SW-1:0] s_sel;
    logic          s_cyc;
    logic          s_stb;
    logic          s_we;
    logic [DW-1:0] s_rdata;
    logic          s_ack;
    logic          s_stall;
    logic          s_err;

    logic slave_stall  = 1'b0;
    logic slave_ack_en = 1'b1;
    logic mon_en       = 1'b1;

    function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
        return 32'h5A5A_0000 ^ {2'b00, a};
    endfunction

    assign s_ack   = slave_ack_en & s_cyc & s_stb & ~slave_stall;
    assign s_stall = slave_stall;
    assign s_err   = 1'b0;
    assign s_rdata = rdata(s_addr);

    wb_arbiter #(
        .Count(N), .DataWidth(DW), .AddrWidth(AW), .TimeoutCycles(TMO)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .wb_m_data_i(m_wdata), .wb_m_addr_i(m_addr), .wb_m_sel_i(m_sel),
        .wb_m_cyc_i(m_cyc), .wb_m_stb_i(m_stb), .wb_m_we_i(m_we),
        .wb_m_data_o(m_rdata), .wb_m_ack_o(m_ack), .wb_m_stall_o(m_stall),
        .wb_m_err_o(m_err),
        .wb_s_data_o(s_wdata), .wb_s_addr_o(s_addr), .wb_s_sel_o(s_sel),
        .wb_s_cyc_o(s_cyc), .wb_s_stb_o(s_stb), .wb_s_we_o(s_we),
        .wb_s_data_i(s_rdata), .wb_s_ack_i(s_ack), .wb_s_stall_i(s_stall),
        .wb_s_err_i(s_err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          we;
        logic [SW-1:0] sel;
        logic [7:0]    gap;   // cycles since previous transfer, 0 = unchecked
    } bus_t;

    bus_t          bus_q [$];
    logic [DW-1:0] ack_q0 [$];
    logic [DW-1:0] ack_q1 [$];

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    int last_x = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    task automatic push_bus(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic we, input logic [7:0] gap);
        bus_t e;
        e.addr = a; e.data = d; e.we = we; e.sel = 4'hF; e.gap = gap;
        bus_q.push_back(e);
    endtask

    // Shared-bus monitor: every accepted transfer must match the next expectation
    always @(negedge clk) begin
        if (mon_en && s_cyc && s_stb && !s_stall) begin
            if (bus_q.size() == 0) begin
                miss("bus_unexpected");
            end else begin
                bus_t e;
                e = bus_q.pop_front();
                check("bus_xfer", {s_addr, s_wdata, s_we, s_sel}, {e.addr, e.data, e.we, e.sel});
                if (e.gap != 0) check("bus_gap", 96'(cyc_n - last_x), 96'(e.gap));
            end
            last_x = cyc_n;
        end
    end

    // Ack monitor: acks only reach the master that issued the request
    always @(negedge clk) begin
        if (m_ack[0]) begin
            if (ack_q0.size() == 0) miss("ack0_unexpected");
            else check("ack0_data", 96'(m_rdata[0]), 96'(ack_q0.pop_front()));
        end
        if (m_ack[1]) begin
            if (ack_q1.size() == 0) miss("ack1_unexpected");
            else check("ack1_data", 96'(m_rdata[1]), 96'(ack_q1.pop_front()));
        end
    end

    // One bus cycle of n single transfers from master m
    task automatic mtx(input int m, input int n, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic we);
        @(posedge clk); #1;
        m_cyc[m] = 1'b1;
        for (int k = 0; k < n; k++) begin
            int b;
            m_stb[m]   = 1'b1;
            m_addr[m]  = a0 + AW'(k);
            m_wdata[m] = d0 + DW'(k);
            m_we[m]    = we;
            m_sel[m]   = 4'hF;
            if (m == 0) ack_q0.push_back(rdata(a0 + AW'(k)));
            else        ack_q1.push_back(rdata(a0 + AW'(k)));
            b = 0;
            do begin
                @(negedge clk);
                b++;
            end while (!m_ack[m] && b < 200);
            if (!m_ack[m]) miss("ack_wait_timeout");
            @(posedge clk); #1;
        end
        m_stb[m] = 1'b0;
        m_cyc[m] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_wdata[i] = '0; m_addr[i] = '0; m_sel[i] = '0;
            m_cyc[i] = 1'b1; m_stb[i] = 1'b0; m_we[i] = 1'b0;
        end

        // Reset held with both masters requesting
        repeat (3) begin
            @(negedge clk);
            check("rst_cyc", 96'(s_cyc), 96'(0));
            check("rst_stall0", 96'(m_stall[0]), 96'(1));
            check("rst_stall1", 96'(m_stall[1]), 96'(1));
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_nogrant", 96'(s_cyc), 96'(0));
        @(negedge clk);
        check("post_rst_cyc", 96'(s_cyc), 96'(1));
        check("post_rst_stall0", 96'(m_stall[0]), 96'(0));
        check("post_rst_stall1", 96'(m_stall[1]), 96'(1));
        @(posedge clk); #1;
        m_cyc[0] = 1'b0; m_cyc[1] = 1'b0;
        @(posedge clk);

        // Single master write with one-cycle grant latency
        push_bus(30'h10, 32'hDEAD_BEEF, 1'b1, 8'd0);
        fork
            mtx(1, 1, 30'h10, 32'hDEAD_BEEF, 1'b1);
            begin
                @(posedge clk);
                @(negedge clk);
                check("grant_latency_cyc", 96'(s_cyc), 96'(0));
                check("grant_latency_stall1", 96'(m_stall[1]), 96'(1));
            end
        join

        // Contention: alternating grants with only the release cycle between
        push_bus(30'h100, 32'h1111_0100, 1'b0, 8'd0);
        push_bus(30'h101, 32'h1111_0101, 1'b0, 8'd1);
        push_bus(30'h200, 32'h2222_0200, 1'b1, 8'd2);
        push_bus(30'h201, 32'h2222_0201, 1'b1, 8'd1);
        push_bus(30'h110, 32'h1111_0110, 1'b0, 8'd2);
        push_bus(30'h111, 32'h1111_0111, 1'b0, 8'd1);
        push_bus(30'h210, 32'h2222_0210, 1'b1, 8'd2);
        push_bus(30'h211, 32'h2222_0211, 1'b1, 8'd1);
        fork
            begin
                mtx(0, 2, 30'h100, 32'h1111_0100, 1'b0);
                mtx(0, 2, 30'h110, 32'h1111_0110, 1'b0);
            end
            begin
                mtx(1, 2, 30'h200, 32'h2222_0200, 1'b1);
                mtx(1, 2, 30'h210, 32'h2222_0210, 1'b1);
            end
        join

        // Slave stall passes through to the owner only
        slave_stall = 1'b1;
        push_bus(30'h300, 32'h3333_0300, 1'b0, 8'd0);
        push_bus(30'h400, 32'h4444_0400, 1'b1, 8'd2);
        fork
            mtx(0, 1, 30'h300, 32'h3333_0300, 1'b0);
            mtx(1, 1, 30'h400, 32'h4444_0400, 1'b1);
            begin
                @(posedge clk);
                @(posedge clk);
                repeat (4) begin
                    @(negedge clk);
                    check("stall_owner", 96'(m_stall[0]), 96'(1));
                    check("stall_stb", 96'(s_stb), 96'(1));
                    check("stall_addr", 96'(s_addr), 96'(30'h300));
                    check("stall_other", 96'(m_stall[1]), 96'(1));
                end
                @(posedge clk); #1 slave_stall = 1'b0;
            end
        join

        // Reset pulse while master 1 owns the bus
        @(posedge clk); #1;
        slave_stall = 1'b1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = 30'h500; m_we[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_own1_addr", 96'(s_addr), 96'(30'h500));
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        slave_stall = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b0; m_addr[0] = 30'h600;
        @(negedge clk);
        check("mid_rst_cyc", 96'(s_cyc), 96'(0));
        check("mid_rst_stall1", 96'(m_stall[1]), 96'(1));
        @(negedge clk);
        check("mid_rst_regrant_cyc", 96'(s_cyc), 96'(1));
        check("mid_rst_regrant_addr", 96'(s_addr), 96'(30'h600));
        check("mid_rst_regrant_stall0", 96'(m_stall[0]), 96'(0));
        check("mid_rst_regrant_stall1", 96'(m_stall[1]), 96'(1));
        @(posedge clk); #1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        repeat (2) @(posedge clk);

        // Slave that never acks
        mon_en = 1'b0;
        slave_ack_en = 1'b0;
        #1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 30'h700; m_we[0] = 1'b0;
        @(posedge clk); #1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = 30'h710;
        bad = 0;
`ifdef WB_ARBITER_TIMEOUT_EN
        repeat (TMO - 1) begin
            @(negedge clk);
            if (!(s_cyc && !m_err[0] && s_addr == 30'h700)) bad++;
        end
        check("tmo_hold_before_err", 96'(bad), 96'(0));
        @(negedge clk);
        check("tmo_err0", 96'(m_err[0]), 96'(1));
        check("tmo_cyc_forced", 96'(s_cyc), 96'(0));
        @(posedge clk); #1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(negedge clk);
        check("tmo_handover_cyc", 96'(s_cyc), 96'(1));
        check("tmo_handover_addr", 96'(s_addr), 96'(30'h710));
        check("tmo_err0_cleared", 96'(m_err[0]), 96'(0));
`else
        repeat (100) begin
            @(negedge clk);
            if (!(s_cyc && !m_err[0] && s_addr == 30'h700 && m_stall[1])) bad++;
        end
        check("hold_100_cycles", 96'(bad), 96'(0));
        @(posedge clk); #1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(negedge clk);
        check("release_cyc", 96'(s_cyc), 96'(0));
        @(negedge clk);
        check("handover_cyc", 96'(s_cyc), 96'(1));
        check("handover_addr", 96'(s_addr), 96'(30'h710));
`endif
        @(posedge clk); #1;
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        repeat (3) @(posedge clk);
        slave_ack_en = 1'b1;
        mon_en = 1'b1;

        check("bus_q_drained", 96'(bus_q.size()), 96'(0));
        check("ack_q0_drained", 96'(ack_q0.size()), 96'(0));
        check("ack_q1_drained", 96'(ack_q1.size()), 96'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
